// File: rtl/mem_stage.sv
// MEM pipeline stage: word load/store over a request/grant + strobe/ready bus,
// alignment check, optional bus-wait timeout, and the MEM pipeline register.
module mem_stage #(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] ex_pc,
  input  logic        ex_en_,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  input  logic        bus_grnt_,
  output logic        bus_req_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  output logic        mem_busy,
  output logic [31:0] mem_fwd_data,
  output logic [29:0] mem_pc,
  output logic        mem_en_,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  // state  | meaning
  // IDLE   | no access in flight; issues request when EX holds an aligned LDW/STW
  // REQ    | bus requested, waiting for grant
  // ACCESS | strobe asserted, waiting for ready (or timeout)
  // DONE   | access finished under stall; result held so the instruction is not re-issued
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

  localparam logic [1:0] OP_LDW = 2'b01;
  localparam logic [1:0] OP_STW = 2'b10;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd2;
  localparam logic [2:0] EXP_BUS_ERR    = 3'd3;
  localparam int TW = 16;
  localparam logic [TW-1:0] TMR_LOAD = (WAIT_TIMEOUT > 0) ? TW'(WAIT_TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [31:0]   rd_buf;
  logic          err_buf;
  logic [TW-1:0] tmr;
  logic          flush_pend;

  logic        is_mem, is_load, misalign, need, timeout, acc_rdy, bus_err, hold;
  logic [2:0]  exp_nxt;

  assign is_mem   = ~ex_en_ & (ex_mem_op == OP_LDW || ex_mem_op == OP_STW);
  assign is_load  = (ex_mem_op == OP_LDW);
  assign misalign = is_mem & (ex_out[1:0] != 2'b00);
  // reset gating keeps strobes released while reset is held
  assign need     = is_mem & (ex_exp_code == 3'd0) & (ex_out[1:0] == 2'b00) & ~reset;
  assign acc_rdy  = ~bus_rdy_;
  assign timeout  = (WAIT_TIMEOUT > 0) && (tmr == '0) && bus_rdy_;

  always_comb begin
    state_nxt    = state;
    bus_req_     = 1'b1;
    bus_as_      = 1'b1;
    bus_rw       = 1'b1;
    bus_addr     = '0;
    bus_wr_data  = '0;
    mem_busy     = 1'b0;
    bus_err      = 1'b0;
    mem_fwd_data = ex_out;
    case (state)
      IDLE: begin
        if (need) begin
          bus_req_  = 1'b0;
          mem_busy  = 1'b1;
          state_nxt = bus_grnt_ ? REQ : ACCESS;
        end
      end
      REQ: begin
        bus_req_ = 1'b0;
        mem_busy = 1'b1;
        if (!bus_grnt_) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus_req_    = 1'b0;
        bus_as_     = 1'b0;
        bus_addr    = ex_out[31:2];
        bus_rw      = is_load;
        bus_wr_data = ex_mem_wr_data;
        if (acc_rdy) begin
          if (is_load) mem_fwd_data = bus_rd_data;
          state_nxt = stall ? DONE : IDLE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = stall ? DONE : IDLE;
        end else begin
          mem_busy = 1'b1;
        end
      end
      DONE: begin
        bus_err = err_buf;
        if (is_load && !err_buf) mem_fwd_data = rd_buf;
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exp_nxt = 3'd0;
    if (ex_exp_code != 3'd0) exp_nxt = ex_exp_code;
    else if (misalign)       exp_nxt = EXP_MISS_ALIGN;
    else if (bus_err)        exp_nxt = EXP_BUS_ERR;
  end

  assign hold = stall | mem_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_buf     <= '0;
      err_buf    <= 1'b0;
      tmr        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != ACCESS && state_nxt == ACCESS) tmr <= TMR_LOAD;
      else if (state == ACCESS)                   tmr <= tmr - 1'b1;
      if (state == ACCESS) begin
        if (acc_rdy) rd_buf <= bus_rd_data;
        err_buf <= bus_err;
      end
      // a flush that lands while the bus cycle is still running is remembered
      if (!hold)                            flush_pend <= 1'b0;
      else if (flush && mem_busy && !stall) flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (!hold && (flush || flush_pend))) begin
      mem_pc       <= '0;
      mem_en_      <= 1'b1;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= '0;
      mem_dst_addr <= '0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= '0;
      mem_out      <= '0;
    end else if (!hold) begin
      mem_pc       <= ex_pc;
      mem_en_      <= ex_en_;
      mem_br_flag  <= ex_br_flag;
      mem_ctrl_op  <= ex_ctrl_op;
      mem_dst_addr <= ex_dst_addr;
      mem_gpr_we_  <= ex_gpr_we_ | (misalign && ex_exp_code == 3'd0) | bus_err;
      mem_exp_code <= exp_nxt;
      mem_out      <= mem_fwd_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions against a transaction-level model of the stage.
module tb_mem_stage;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [29:0] ex_pc;
  logic        ex_en_, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out, bus_rd_data;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic        bus_rdy_, bus_grnt_;
  logic        bus_req_, bus_as_, bus_rw, mem_busy;
  logic [29:0] bus_addr, mem_pc;
  logic [31:0] bus_wr_data, mem_fwd_data, mem_out;
  logic        mem_en_, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;

  int checks = 0;
  int errors = 0;

  mem_stage #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_en_(ex_en_), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
    .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .mem_busy(mem_busy), .mem_fwd_data(mem_fwd_data),
    .mem_pc(mem_pc), .mem_en_(mem_en_), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; ex_en_ = 1'b1; ex_mem_op = 2'b00;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_en"}, 32'(mem_en_), 32'd1);
    chk({tag, "_gpr"}, 32'(mem_gpr_we_), 32'd1);
    chk({tag, "_exp"}, 32'(mem_exp_code), 32'd0);
    chk({tag, "_out"}, mem_out, 32'd0);
    chk({tag, "_pc"}, 32'(mem_pc), 32'd0);
  endtask

  // One instruction through MEM: g = grant delay, d = ready delay (ACCESS cycles before
  // ready), xs = stall cycles starting at completion, fl = flush during the access.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [2:0] exc, input logic en_n, input logic gwe,
                        input int g, input int d, input int xs, input bit fl);
    logic [29:0] pc = 30'($urandom);
    logic [4:0]  dst = 5'($urandom);
    logic [1:0]  cop = 2'($urandom);
    logic        br = 1'($urandom);
    bit memop = !en_n && (op == 2'b01 || op == 2'b10);
    bit mis = memop && addr[1:0] != 2'b00;
    bit acc = memop && exc == 3'd0 && !mis;
    bit to = acc && d >= TO;
    int exp_busy = acc ? g + 1 + (to ? TO - 1 : d) : 0;
    int exp_acc = acc ? (to ? TO : d + 1) : 0;
    int exp_hits = (acc && !to) ? 1 : 0;
    logic [31:0] exp_out = (acc && !to && op == 2'b01) ? rdata : addr;
    logic [2:0] exp_exc = (exc != 3'd0) ? exc : mis ? 3'd2 : to ? 3'd3 : 3'd0;
    logic exp_gpr = gwe | (mis && exc == 3'd0) | to;
    int reqc = 0, accc = 0, busyc = 0, hits = 0, rem = xs;
    bit comp = 0, fin = 0;

    ex_pc = pc; ex_en_ = en_n; ex_br_flag = br; ex_mem_op = op; ex_mem_wr_data = wdata;
    ex_ctrl_op = cop; ex_dst_addr = dst; ex_gpr_we_ = gwe; ex_exp_code = exc; ex_out = addr;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; stall = 1'b0;
      flush = (fl && !acc && cyc == 0);
      #1;
      if (bus_req_ == 1'b0) begin
        reqc++;
        if (reqc > g) bus_grnt_ = 1'b0;
      end
      if (bus_as_ == 1'b0) begin
        accc++;
        if (accc == 1) begin
          chk({tag, "_addr"}, 32'(bus_addr), 32'(addr[31:2]));
          chk({tag, "_rw"}, 32'(bus_rw), 32'(op == 2'b01));
          chk({tag, "_wdata"}, bus_wr_data, wdata);
          if (fl) flush = 1'b1;
        end
        if (accc > d) begin
          bus_rdy_ = 1'b0; bus_rd_data = rdata; hits++;
        end
      end
      #1;
      if (mem_busy) busyc++;
      else begin
        if (!comp) chk({tag, "_fwd"}, mem_fwd_data, exp_out);
        comp = 1;
        stall = (rem > 0);
        if (rem > 0) rem--;
      end
      fin = comp && !stall;
      @(posedge clk); #1;
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    idle_inputs();
    bus_rd_data = 32'hBAD0BAD0;
    #1;
    chk({tag, "_busy_cycles"}, 32'(busyc), 32'(exp_busy));
    chk({tag, "_acc_cycles"}, 32'(accc), 32'(exp_acc));
    chk({tag, "_hits"}, 32'(hits), 32'(exp_hits));
    if (fl) chk_bubble({tag, "_flush"});
    else begin
      chk({tag, "_en"}, 32'(mem_en_), 32'(en_n));
      chk({tag, "_pc"}, 32'(mem_pc), 32'(pc));
      chk({tag, "_side"}, {24'd0, mem_br_flag, mem_ctrl_op, mem_dst_addr},
          {24'd0, br, cop, dst});
      chk({tag, "_gpr"}, 32'(mem_gpr_we_), 32'(exp_gpr));
      chk({tag, "_exp"}, 32'(mem_exp_code), 32'(exp_exc));
      chk({tag, "_out"}, mem_out, exp_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    ex_pc = '0; ex_br_flag = 1'b0; ex_mem_wr_data = '0; ex_ctrl_op = '0;
    ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = '0; ex_out = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_bubble("rst");
    chk("rst_req", 32'(bus_req_), 32'd1);
    chk("rst_as", 32'(bus_as_), 32'd1);
    chk("rst_rw", 32'(bus_rw), 32'd1);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", bus_wr_data, 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("ldw", 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0, 0, 2, 0, 0);
    run_op("stw", 2'b10, 32'h204, 32'h12345678, 32'h0, 3'd0, 1'b0, 1'b1, 0, 0, 0, 0);
    run_op("mis", 2'b01, 32'h102, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1, 0, 0, 0);
    run_op("ldw_stall", 2'b01, 32'h300, 32'h0, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 1, 1, 3, 0);
    run_op("ldw_flush", 2'b01, 32'h400, 32'h0, 32'h55AA55AA, 3'd0, 1'b0, 1'b0, 0, 3, 0, 1);
    run_op("prior_exc", 2'b10, 32'h500, 32'h1, 32'h0, 3'd5, 1'b0, 1'b1, 0, 0, 0, 0);
    run_op("bus_to", 2'b01, 32'h600, 32'h0, 32'h77, 3'd0, 1'b0, 1'b0, 2, 100, 0, 0);
    run_op("bus_to_stall", 2'b10, 32'h604, 32'h9, 32'h0, 3'd0, 1'b0, 1'b1, 0, 100, 2, 0);

    // reset in the middle of an access
    ex_en_ = 1'b0; ex_mem_op = 2'b01; ex_out = 32'h700; ex_exp_code = 3'd0;
    #1;
    bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_as_before", 32'(bus_as_), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    bus_grnt_ = 1'b1;
    #1;
    chk("mid_rst_as", 32'(bus_as_), 32'd1);
    chk("mid_rst_req", 32'(bus_req_), 32'd1);
    chk("mid_rst_busy", 32'(mem_busy), 32'd0);
    chk_bubble("mid_rst");
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : 2'(r - 8) * 2'd3;
      logic [31:0] a = $urandom;
      bit fl = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("rnd", op, a, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
             ($urandom_range(0, 9) == 0), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 4),
             fl ? 0 : $urandom_range(0, 2), fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
